// File: rtl/rv_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time and
// buffers returned instructions with their PCs in a 2-entry queue for decode.
module rv_fetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,

  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,

  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,

  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr
);

  typedef enum logic [1:0] {
    StReq   = 2'd0,
    StWait  = 2'd1,
    StDrain = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            req_valid_q, req_valid_d;
  logic [1:0]      count_q, count_d;
  logic [XLEN-1:0] q_pc_q    [2];
  logic [XLEN-1:0] q_pc_d    [2];
  logic [31:0]     q_instr_q [2];
  logic [31:0]     q_instr_d [2];

  logic            req_fire;
  logic            pop;
  logic            push;
  logic [1:0]      base;
  logic [XLEN-1:0] redirect_target;
  logic            unused_redirect_lsb;

  assign req_fire            = req_valid_q && imem_req_ready;
  assign pop                 = (count_q != 2'd0) && id_ready;
  assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Control FSM and PC update; a redirect overrides the PC in every state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    push     = 1'b0;

    case (state_q)
      StReq: begin
        if (req_fire) begin
          req_pc_d = pc_q;
          state_d  = redirect_valid ? StDrain : StWait;
        end
      end
      StWait: begin
        if (imem_rsp_valid) begin
          state_d = StReq;
          if (!redirect_valid) begin
            push = 1'b1;
            pc_d = req_pc_q + XLEN'(4);
          end
        end else if (redirect_valid) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (imem_rsp_valid) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase

    if (redirect_valid) begin
      pc_d = redirect_target;
    end
  end

  // Queue: entry 0 is the head; a pop shifts entry 1 down before any push.
  always_comb begin
    q_pc_d    = q_pc_q;
    q_instr_d = q_instr_q;
    count_d   = count_q;
    base      = count_q - {1'b0, pop};

    if (redirect_valid) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        q_pc_d[0]    = q_pc_q[1];
        q_instr_d[0] = q_instr_q[1];
      end
      if (push) begin
        q_pc_d[base[0]]    = req_pc_q;
        q_instr_d[base[0]] = imem_rsp_data;
      end
      count_d = base + {1'b0, push};
    end
  end

  // Registered request valid: only issue when the queue can absorb the reply.
  assign req_valid_d = (state_d == StReq) && (count_d <= 2'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StReq;
      pc_q         <= RESET_VECTOR;
      req_pc_q     <= RESET_VECTOR;
      req_valid_q  <= 1'b0;
      count_q      <= 2'd0;
      q_pc_q[0]    <= '0;
      q_pc_q[1]    <= '0;
      q_instr_q[0] <= '0;
      q_instr_q[1] <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      req_valid_q  <= req_valid_d;
      count_q      <= count_d;
      q_pc_q       <= q_pc_d;
      q_instr_q    <= q_instr_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign id_valid       = (count_q != 2'd0);
  assign id_pc          = q_pc_q[0];
  assign id_instr       = q_instr_q[0];

  // A response with no request outstanding is a memory-side protocol error.
  a_no_rsp_in_req: assert property (@(posedge clk) disable iff (!rst)
    !(imem_rsp_valid && (state_q == StReq)));

  a_count_bound: assert property (@(posedge clk) disable iff (!rst)
    count_q != 2'd3);

  a_req_stable: assert property (@(posedge clk) disable iff (!rst)
    (req_valid_q && !imem_req_ready && !redirect_valid) |=>
      (req_valid_q && $stable(pc_q)));

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed bench for rv_fetch_unit: a second instance with a near-wrap reset
// vector shares all inputs and therefore follows the same control timeline.
module tb_rv_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_id_valid;
  logic [31:0] w_id_pc;
  logic [31:0] w_id_instr;

  int checks   = 0;
  int failures = 0;
  int mem_lat  = 1;

  rv_fetch_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
  );

  rv_fetch_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'hFFFF_FFF8)
  ) u_wrap (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (w_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (w_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (w_id_valid),
    .id_ready       (id_ready),
    .id_pc          (w_id_pc),
    .id_instr       (w_id_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Memory model: one reply per accepted request, mem_lat cycles later.
  initial begin : mem_model
    logic        pend;
    logic [31:0] pend_addr;
    int          wait_cnt;
    pend           = 1'b0;
    pend_addr      = '0;
    wait_cnt       = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      if (rst && imem_req_valid && imem_req_ready) begin
        pend      = 1'b1;
        pend_addr = imem_req_addr;
        wait_cnt  = mem_lat;
      end
      #1;
      if (!rst) pend = 1'b0;
      imem_rsp_valid = 1'b0;
      if (pend) begin
        wait_cnt = wait_cnt - 1;
        if (wait_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = instr_of(pend_addr);
          pend           = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
    chk({tag, "_req_addr"},  64'(imem_req_addr),  64'h0);
    chk({tag, "_id_valid"},  64'(id_valid),       64'd0);
    chk({tag, "_id_pc"},     64'(id_pc),          64'h0);
    chk({tag, "_id_instr"},  64'(id_instr),       64'h0);
    chk({tag, "_w_addr"},    64'(w_req_addr),     64'hFFFF_FFF8);
    chk({tag, "_w_id_pc"},   64'(w_id_pc),        64'h0);
  endtask

  initial begin : stim
    rst            = 1'b0;
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Basic streaming, 1-cycle latency; the wrap instance crosses 2^32.
    tick(); tick();
    chk_reset_outputs("rst0");
    rst = 1'b1;
    tick();
    chk("s1_req_valid", 64'(imem_req_valid), 64'd1);
    chk("s1_req_addr",  64'(imem_req_addr),  64'h0);
    chk("s1_w_addr",    64'(w_req_addr),     64'hFFFF_FFF8);
    tick();
    chk("s1_wait_valid", 64'(imem_req_valid), 64'd0);
    tick();
    chk("s1_id_valid0", 64'(id_valid),       64'd1);
    chk("s1_id_pc0",    64'(id_pc),          64'h0);
    chk("s1_id_ins0",   64'(id_instr),       64'(instr_of(32'h0)));
    chk("s1_addr4",     64'(imem_req_addr),  64'h4);
    chk("s1_valid4",    64'(imem_req_valid), 64'd1);
    chk("s1_w_id_pc0",  64'(w_id_pc),        64'hFFFF_FFF8);
    chk("s1_w_addr1",   64'(w_req_addr),     64'hFFFF_FFFC);
    tick();
    chk("s1_popped", 64'(id_valid), 64'd0);
    tick();
    chk("s1_id_pc4",   64'(id_pc),         64'h4);
    chk("s1_id_ins4",  64'(id_instr),      64'(instr_of(32'h4)));
    chk("s1_addr8",    64'(imem_req_addr), 64'h8);
    chk("s1_w_id_pc1", 64'(w_id_pc),       64'hFFFF_FFFC);
    chk("s1_w_wrap",   64'(w_req_addr),    64'h0);
    tick(); tick();
    chk("s1_id_pc8",   64'(id_pc),      64'h8);
    chk("s1_w_id_pc2", 64'(w_id_pc),    64'h0);
    chk("s1_w_addr3",  64'(w_req_addr), 64'h4);

    // Back-pressure fills both queue entries and stalls fetch.
    rst      = 1'b0;
    id_ready = 1'b0;
    #1;
    chk("rst1_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst1_id_valid",  64'(id_valid),       64'd0);
    tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("s2_full_valid", 64'(id_valid),       64'd1);
    chk("s2_full_pc",    64'(id_pc),          64'h0);
    chk("s2_stall",      64'(imem_req_valid), 64'd0);
    tick();
    chk("s2_stall_hold", 64'(imem_req_valid), 64'd0);
    chk("s2_hold_pc",    64'(id_pc),          64'h0);
    chk("s2_hold_ins",   64'(id_instr),       64'(instr_of(32'h0)));
    id_ready = 1'b1;
    tick();
    chk("s2_pop_pc",    64'(id_pc),          64'h4);
    chk("s2_req8",      64'(imem_req_valid), 64'd1);
    chk("s2_req8_addr", 64'(imem_req_addr),  64'h8);
    tick(); tick();
    chk("s2_id_pc8", 64'(id_pc), 64'h8);

    // Redirect while waiting on 0x4 with one entry buffered.
    rst      = 1'b0;
    mem_lat  = 2;
    id_ready = 1'b0;
    tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("s3_id_pc0", 64'(id_pc),         64'h0);
    chk("s3_addr4",  64'(imem_req_addr), 64'h4);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    chk("s3_flushed",   64'(id_valid),       64'd0);
    chk("s3_drain_req", 64'(imem_req_valid), 64'd0);
    tick();
    chk("s3_req_valid", 64'(imem_req_valid), 64'd1);
    chk("s3_req_addr",  64'(imem_req_addr),  64'h100);
    chk("s3_no_stale",  64'(id_valid),       64'd0);
    mem_lat = 1;
    tick();
    chk("s3_empty", 64'(id_valid), 64'd0);
    tick();
    chk("s3_id_valid", 64'(id_valid), 64'd1);
    chk("s3_id_pc",    64'(id_pc),    64'h100);
    chk("s3_id_ins",   64'(id_instr), 64'(instr_of(32'h100)));

    // Redirect to an unaligned target, same cycle as a response and a pop.
    id_ready = 1'b0;
    tick();
    chk("s4_pre_valid", 64'(id_valid), 64'd1);
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick();
    redirect_valid = 1'b0;
    chk("s4_flushed",  64'(id_valid),       64'd0);
    chk("s4_req",      64'(imem_req_valid), 64'd1);
    chk("s4_req_addr", 64'(imem_req_addr),  64'h200);
    tick();
    chk("s4_dropped", 64'(id_valid), 64'd0);
    tick();
    chk("s4_id_pc",  64'(id_pc),    64'h200);
    chk("s4_id_ins", 64'(id_instr), 64'(instr_of(32'h200)));

    // Redirect coincident with the handshake for 0x8.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("s5_addr8",  64'(imem_req_addr),  64'h8);
    chk("s5_valid8", 64'(imem_req_valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick();
    redirect_valid = 1'b0;
    chk("s5_drain_req", 64'(imem_req_valid), 64'd0);
    chk("s5_flushed",   64'(id_valid),       64'd0);
    tick();
    chk("s5_req",      64'(imem_req_valid), 64'd1);
    chk("s5_req_addr", 64'(imem_req_addr),  64'h300);
    tick();
    chk("s5_no_8", 64'(id_valid), 64'd0);
    tick();
    chk("s5_id_pc",  64'(id_pc),    64'h300);
    chk("s5_id_ins", 64'(id_instr), 64'(instr_of(32'h300)));

    // Asynchronous reset in the middle of a WAIT with a buffered entry.
    rst      = 1'b0;
    mem_lat  = 2;
    id_ready = 1'b0;
    tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("s6_pre_valid", 64'(id_valid), 64'd1);
    chk("s6_pre_w_pc",  64'(w_id_pc),  64'hFFFF_FFF8);
    #3;
    rst = 1'b0;
    #1;
    chk_reset_outputs("s6_async");
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("s6_restart_valid", 64'(imem_req_valid), 64'd1);
    chk("s6_restart_addr",  64'(imem_req_addr),  64'h0);
    chk("s6_restart_empty", 64'(id_valid),       64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
